lcg_csa_seq: RTL and testbench
==============================

Name: lcg_csa_seq

Overview:
- Sequential mixed linear congruential generator step: x_next = (A_MULT * x + C_INC) mod 2^W.
- The multiply runs shift-and-add, one multiplier bit per cycle, into a carry-save accumulator. That accumulator is a row of 3:2 compressors built from the existing full-adder and half-adder cells.
- A final carry-propagate cycle resolves the sum/carry vectors into the new state.
- Downstream of the CSA cell rows, it consumes their sum/carry outputs. It serves as the per-generator engine that the MDCLCG combiner instantiates twice.

Parameters:
- W, 16, state / output width in bits.
- A_MULT, 16'h4E35, multiplier (A_MULT mod 4 == 1 for full period).
- C_INC, 16'h0001, increment (odd for full period).
- SEED_RST, 16'h0000, state value loaded by reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- seed_load  input  1  load seed into state; highest priority after rst.
- seed  input  W  seed value, sampled when seed_load=1.
- start  input  1  request one LCG step; sampled only in IDLE.
- busy  output  1  high while a step is in progress.
- valid  output  1  one-cycle pulse, new rnd_out available.
- rnd_out  output  W  current generator state x.

The interface uses one clock; reset is synchronous and active-high.

Behaviour:
- Reset values (rst=1 at an edge): state x=SEED_RST, rnd_out=SEED_RST, busy=0, valid=0, FSM=IDLE, S=0, C=0, cnt=0.
- FSM states are IDLE, MUL, RESOLVE.
- IDLE:
  - seed_load=1 -> x<=seed, stay IDLE, valid stays 0.
  - Else start=1 -> S<=C_INC, C<=0, cnt<=0, busy<=1, go to MUL.
  - seed_load and start together in IDLE: seed loads, start is dropped.
- MUL (exactly W cycles, independent of A_MULT bit values):
  - P = A_MULT[cnt] ? (x << cnt) mod 2^W : 0.
  - S<=S^C^P.
  - C<=((S&C)|(S&P)|(C&P))<<1, truncated to W bits.
  - cnt<=cnt+1; when cnt==W-1, go to RESOLVE.
- RESOLVE (1 cycle):
  - x<=(S+C) mod 2^W, which is a W-bit carry-propagate add with the carry-out discarded.
  - valid<=1, busy<=0, go to IDLE.
- valid is high for exactly one cycle; all other cycles it is 0.
- rnd_out is x at all times and holds between steps.
- Latency:
  - The edge that samples start is edge 1; valid and the new rnd_out appear after edge W+2 (18 for W=16).
  - busy is high after edges 1..W+1.
- Back-to-back: start high while valid=1 (FSM in IDLE) is accepted and begins the next step from the new x. Throughput is one step per W+2 cycles.
- start while busy=1 is ignored (not queued).
- seed_load while busy: aborts the step, x<=seed, S/C/cnt cleared, busy<=0, FSM=IDLE, no valid pulse.
- rst at any state or cycle overrides everything, including seed_load.
- All arithmetic is unsigned mod 2^W.
- x is read unchanged throughout MUL, since x is only written in RESOLVE or on seed_load.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=2'd0, MUL=2'd1, RESOLVE=2'd2) and the default A_MULT/C_INC/SEED_RST constants used by both MDCLCG generator instances.
- One sub-module, csa_row (parameter W): combinational W-bit 3:2 compressor taking S, C, P and producing S', C'<<1. It is built as a generate row of the existing full-adder cells. The top block holds the FSM, counter, registers and final resolve adder.

Test Plan:
- Reset then seed_load seed=16'h0001, start pulse -> busy high 17 cycles, valid pulse after edge 18, rnd_out=16'h4E36.
- Immediately restart on the valid cycle from 16'h4E36 -> next valid 18 edges later with rnd_out=16'hA52F.
- seed=16'h0000, start -> rnd_out=16'h0001; seed=16'hFFFF, start -> rnd_out=16'hB1CC, which checks carry-out discard and wrap.
- start at MUL cycle 5 is ignored; seed_load=1 seed=16'h1234 at MUL cycle 8 -> busy drops next cycle, no valid pulse, rnd_out=16'h1234.
- seed_load and start in the same IDLE cycle with seed=16'h00FF -> rnd_out=16'h00FF, busy stays 0, no valid.
- rst asserted mid-MUL (with seed_load also high) -> next cycle rnd_out=SEED_RST, busy=0, valid=0.
- Random-seed run of 1000 chained steps checked against a reference model (A*x+C) mod 2^16.

Source files
------------

// File: rtl/lcg_csa_seq_pkg.sv
// ---------------------------------------------------------------------------
// lcg_csa_seq_pkg : shared FSM encoding and default LCG constants
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lcg_csa_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL     = 2'd1,
    RESOLVE = 2'd2
  } lcg_state_t;

  localparam logic [15:0] LCG_A_MULT   = 16'h4E35;
  localparam logic [15:0] LCG_C_INC    = 16'h0001;
  localparam logic [15:0] LCG_SEED_RST = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/lcg_csa_seq_csa_row.sv
// ---------------------------------------------------------------------------
// csa_row : W-bit 3:2 compressor row, carry vector returned pre-shifted
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csa_row #(
  parameter int W = 16
) (
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] c_in,
  input  logic [W-1:0] p_in,
  output logic [W-1:0] s_out,
  output logic [W-1:0] c_out
);

  logic [W-2:0] carry;

  generate
    for (genvar i = 0; i < W; i++) begin : g_fa
      if (i < W - 1) begin : g_full
        assign s_out[i] = s_in[i] ^ c_in[i] ^ p_in[i];
        assign carry[i] = (s_in[i] & c_in[i]) | (s_in[i] & p_in[i]) | (c_in[i] & p_in[i]);
      end else begin : g_msb
        // Carry out of the top bit would shift past bit W-1, so it is never built
        assign s_out[i] = s_in[i] ^ c_in[i] ^ p_in[i];
      end
    end
  endgenerate

  assign c_out = {carry, 1'b0};

endmodule

`default_nettype wire

// File: rtl/lcg_csa_seq.sv
// ---------------------------------------------------------------------------
// lcg_csa_seq : sequential LCG step x' = A*x + C, shift-and-add into CSA
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcg_csa_seq
  import lcg_csa_seq_pkg::*;
#(
  parameter int           W        = 16,
  parameter logic [W-1:0] A_MULT   = LCG_A_MULT,
  parameter logic [W-1:0] C_INC    = LCG_C_INC,
  parameter logic [W-1:0] SEED_RST = LCG_SEED_RST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_load,
  input  logic [W-1:0] seed,
  input  logic         start,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] rnd_out
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  lcg_state_t   state, state_next;
  logic [W-1:0] x, x_next;
  logic [W-1:0] s_acc, s_next;
  logic [W-1:0] c_acc, c_next;
  logic [CW-1:0] cnt, cnt_next;
  logic         busy_next, valid_next;

  logic [W-1:0] pp;
  logic [W-1:0] csa_s, csa_c;
  logic [W-1:0] resolved;

  assign pp       = A_MULT[cnt] ? (x << cnt) : '0;
  assign resolved = s_acc + c_acc;

  csa_row #(.W(W)) u_csa_row (
    .s_in  (s_acc),
    .c_in  (c_acc),
    .p_in  (pp),
    .s_out (csa_s),
    .c_out (csa_c)
  );

  always_comb begin
    state_next = state;
    x_next     = x;
    s_next     = s_acc;
    c_next     = c_acc;
    cnt_next   = cnt;
    busy_next  = busy;
    valid_next = 1'b0;

    // seed_load wins in every state and silently aborts a step in flight
    if (seed_load) begin
      state_next = IDLE;
      x_next     = seed;
      s_next     = '0;
      c_next     = '0;
      cnt_next   = '0;
      busy_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = MUL;
            s_next     = C_INC;
            c_next     = '0;
            cnt_next   = '0;
            busy_next  = 1'b1;
          end
        end
        MUL: begin
          s_next   = csa_s;
          c_next   = csa_c;
          cnt_next = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state_next = RESOLVE;
          end
        end
        RESOLVE: begin
          state_next = IDLE;
          x_next     = resolved;
          valid_next = 1'b1;
          busy_next  = 1'b0;
        end
        default: begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= SEED_RST;
      s_acc <= '0;
      c_acc <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      x     <= x_next;
      s_acc <= s_next;
      c_acc <= c_next;
      cnt   <= cnt_next;
      busy  <= busy_next;
      valid <= valid_next;
    end
  end

  assign rnd_out = x;

endmodule

`default_nettype wire

// File: tb/tb_lcg_csa_seq.sv
// ---------------------------------------------------------------------------
// tb_lcg_csa_seq : vector table, corner sequences and random chained steps
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lcg_csa_seq;

  localparam int          W       = 16;
  localparam logic [31:0] A_REF   = 32'h0000_4E35;
  localparam logic [31:0] C_REF   = 32'h0000_0001;

  logic         clk = 1'b0;
  logic         rst;
  logic         seed_load;
  logic [W-1:0] seed;
  logic         start;
  logic         busy;
  logic         valid;
  logic [W-1:0] rnd_out;

  int asserts  = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] seed;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[4];

  lcg_csa_seq dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .busy      (busy),
    .valid     (valid),
    .rnd_out   (rnd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] xv);
    logic [31:0] prod;
    prod = A_REF * {16'h0, xv} + C_REF;
    return prod[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_seed(input logic [W-1:0] v);
    seed_load = 1'b1;
    seed      = v;
    tick();
    seed_load = 1'b0;
    chk("seed_rnd", 32'(rnd_out), 32'(v));
    chk("seed_busy", 32'(busy), 0);
  endtask

  // Launch a step and wait for its valid pulse; returns at #1 after the valid edge
  task automatic run_step(input logic [W-1:0] exp, input bit full);
    int  e;
    bit  seen;
    bit  busy_ok;
    seen    = 1'b0;
    busy_ok = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    if (full) chk("busy_edge1", 32'(busy), 1);
    for (e = 2; e <= 40; e++) begin
      tick();
      if (valid) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    chk("valid_seen", 32'(seen), 1);
    if (seen) begin
      chk("step_rnd", 32'(rnd_out), 32'(exp));
      if (full) begin
        chk("latency", 32'(e), 32'(W + 2));
        chk("busy_during", 32'(busy_ok), 1);
        chk("busy_at_valid", 32'(busy), 0);
      end
    end
  endtask

  initial begin
    logic [W-1:0] xm;
    bit           any_valid;

    vecs[0] = '{seed: 16'h0001, exp: 16'h4E36};
    vecs[1] = '{seed: 16'h0000, exp: 16'h0001};
    vecs[2] = '{seed: 16'hFFFF, exp: 16'hB1CC};
    vecs[3] = '{seed: 16'h4E36, exp: 16'hA52F};

    rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0;
    tick();
    tick();
    chk("rst_rnd", 32'(rnd_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    rst = 1'b0;
    tick();

    // Table of single steps from fixed seeds
    for (int i = 0; i < 4; i++) begin
      do_seed(vecs[i].seed);
      run_step(vecs[i].exp, 1'b1);
      tick();
      chk("valid_one_cycle", 32'(valid), 0);
      chk("hold_rnd", 32'(rnd_out), 32'(vecs[i].exp));
    end

    // Back-to-back: restart on the valid cycle
    do_seed(16'h0001);
    run_step(16'h4E36, 1'b1);
    run_step(16'hA52F, 1'b1);
    tick();

    // Start mid-MUL ignored, then seed_load aborts the step
    do_seed(16'h0042);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("busy_mid_mul", 32'(busy), 1);
    seed_load = 1'b1; seed = 16'h1234;
    tick();
    seed_load = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_rnd", 32'(rnd_out), 32'h1234);
    any_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (valid || busy) any_valid = 1'b1;
    end
    chk("abort_quiet", 32'(any_valid), 0);
    chk("abort_hold", 32'(rnd_out), 32'h1234);

    // seed_load and start together in IDLE: seed wins, start dropped
    seed_load = 1'b1; seed = 16'h00FF; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    chk("both_rnd", 32'(rnd_out), 32'h00FF);
    chk("both_busy", 32'(busy), 0);
    any_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (valid || busy) any_valid = 1'b1;
    end
    chk("both_quiet", 32'(any_valid), 0);

    // Reset mid-MUL overrides a concurrent seed_load
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1; seed_load = 1'b1; seed = 16'hABCD;
    tick();
    rst = 1'b0; seed_load = 1'b0;
    chk("midrst_rnd", 32'(rnd_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(valid), 0);
    run_step(16'h0001, 1'b1);
    tick();

    // Random chained steps against the arithmetic model
    xm = 16'($urandom);
    do_seed(xm);
    for (int n = 0; n < 1000; n++) begin
      if (n % 250 == 249) begin
        tick();
        xm = 16'($urandom);
        do_seed(xm);
      end
      xm = ref_step(xm);
      run_step(xm, (n % 97) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

`default_nettype wire
